// File: rtl/jump_controller.sv
// jump_controller
//   Game-flow controller for a layer-jumping game. It turns debounced button
//   presses into single-cycle jump strobes and produces a pseudo-random next
//   layer on each jump. After a jump it waits out a lockout of JUMP_MS
//   millisecond ticks, then reads the datapath's failure flag. That flag
//   decides between scoring the jump and ending the game.
//
//   Optional feature (macro JUMP_BUFFER_EN): a one-entry jump buffer. When it
//   is enabled, the first single-button press seen during the lockout is
//   replayed as a strobe in the first PLAY cycle after a successful jump.
//
//   Parameters
//     JUMP_MS    lockout length in one_ms_tick pulses (1..1023)
//     LFSR_SEED  nonzero 14-bit LFSR reset value
//   Ports
//     clk, rst     clock; synchronous active-high reset
//     one_ms_tick  1-cycle pulse every millisecond
//     btn_left     debounced left request (level)
//     btn_right    debounced right request (level)
//     jump_fail    failure flag from the layer datapath
//     blocks_en    datapath enable (0 in IDLE)
//     jump_left    1-cycle left-jump strobe
//     jump_right   1-cycle right-jump strobe
//     layer_map    new top-layer occupancy, bit 0 leftmost
//     block_type   new top-layer hazard flags, bit 0 leftmost
//     score        completed jumps, saturating at 999
//     game_state   0 IDLE, 1 PLAY, 2 BUSY, 3 OVER
module jump_controller #(
  parameter int unsigned JUMP_MS   = 250,
  parameter logic [13:0] LFSR_SEED = 14'h2A5D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_ms_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       jump_fail,
  output logic       blocks_en,
  output logic       jump_left,
  output logic       jump_right,
  output logic [6:0] layer_map,
  output logic [6:0] block_type,
  output logic [9:0] score,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    BUSY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [9:0] CNT_LAST  = 10'(JUMP_MS - 1);
  localparam logic [9:0] SCORE_MAX = 10'd999;

  state_t      state, state_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [13:0] lfsr, lfsr_nxt, lfsr_stepped;
  logic [6:0]  map_nxt, type_nxt;
  logic [9:0]  score_nxt;
  logic        jl_nxt, jr_nxt;
  logic        prev_left, prev_right;
  logic        armed;
  logic        press_left, press_right, single;
  logic        do_jump, dir_left;

`ifdef JUMP_BUFFER_EN
  logic buf_valid, buf_left;
  logic pend_valid, pend_left;
`endif

  // armed stays low for the first cycle after reset. A button held through
  // reset release is therefore copied into prev_* before any edge is taken.
  assign press_left  = armed & btn_left  & ~prev_left;
  assign press_right = armed & btn_right & ~prev_right;
  assign single      = press_left ^ press_right;

  // Fibonacci LFSR, taps 14,13,12,2. This is the value after one step.
  assign lfsr_stepped = {lfsr[12:0], lfsr[13] ^ lfsr[12] ^ lfsr[11] ^ lfsr[1]};

  assign blocks_en  = (state != IDLE);
  assign game_state = state;

`ifdef JUMP_BUFFER_EN
  // A press arriving in the same cycle as the final tick counts as buffered.
  assign pend_valid = buf_valid | single;
  assign pend_left  = buf_valid ? buf_left : press_left;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    map_nxt   = layer_map;
    type_nxt  = block_type;
    score_nxt = score;
    jl_nxt    = 1'b0;
    jr_nxt    = 1'b0;
    do_jump   = 1'b0;
    dir_left  = 1'b0;

    unique case (state)
      IDLE: begin
        if (press_left | press_right) begin
          state_nxt = PLAY;
          score_nxt = '0;
        end
      end
      PLAY: begin
`ifdef JUMP_BUFFER_EN
        // A strobe that is high while in PLAY is a replayed buffered jump.
        // That jump is already issued, so enter the lockout directly.
        if (jump_left | jump_right) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end else
`endif
        if (single) begin
          do_jump   = 1'b1;
          dir_left  = press_left;
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (one_ms_tick) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (jump_fail) begin
              state_nxt = OVER;
            end else begin
              state_nxt = PLAY;
              score_nxt = (score == SCORE_MAX) ? score : score + 10'd1;
`ifdef JUMP_BUFFER_EN
              if (pend_valid) begin
                do_jump  = 1'b1;
                dir_left = pend_left;
              end
`endif
            end
          end else begin
            cnt_nxt = cnt + 10'd1;
          end
        end
      end
      OVER: begin
        if (press_left | press_right) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (do_jump) begin
      lfsr_nxt = lfsr_stepped;
      map_nxt  = lfsr_stepped[6:0] | 7'b0001000;
      type_nxt = lfsr_stepped[13:7] & map_nxt & 7'b1110111;
      jl_nxt   = dir_left;
      jr_nxt   = ~dir_left;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lfsr       <= LFSR_SEED;
      layer_map  <= '0;
      block_type <= '0;
      score      <= '0;
      jump_left  <= 1'b0;
      jump_right <= 1'b0;
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lfsr       <= lfsr_nxt;
      layer_map  <= map_nxt;
      block_type <= type_nxt;
      score      <= score_nxt;
      jump_left  <= jl_nxt;
      jump_right <= jr_nxt;
      prev_left  <= btn_left;
      prev_right <= btn_right;
      armed      <= 1'b1;
    end
  end

`ifdef JUMP_BUFFER_EN
  // The buffer lives only while BUSY continues. Any exit from BUSY clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_left  <= 1'b0;
    end else if (state == BUSY && state_nxt == BUSY) begin
      if (!buf_valid && single) begin
        buf_valid <= 1'b1;
        buf_left  <= press_left;
      end
    end else begin
      buf_valid <= 1'b0;
      buf_left  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_jump_controller.sv
// Testbench for jump_controller. It drives directed sequences first, then a
// long saturating run and a random phase. A behavioural game model inside the
// bench supplies the expected value of every output on every cycle.
module tb_jump_controller;

  localparam int unsigned JMS  = 3;
  localparam logic [13:0] SEED = 14'h2A5D;
`ifdef JUMP_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, one_ms_tick, btn_left, btn_right, jump_fail;
  logic       blocks_en, jump_left, jump_right;
  logic [6:0] layer_map, block_type;
  logic [9:0] score;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  jump_controller #(.JUMP_MS(JMS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick),
    .btn_left(btn_left), .btn_right(btn_right), .jump_fail(jump_fail),
    .blocks_en(blocks_en), .jump_left(jump_left), .jump_right(jump_right),
    .layer_map(layer_map), .block_type(block_type), .score(score),
    .game_state(game_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Game model. m_state: 0 idle, 1 play, 2 busy, 3 over.
  int       m_state, m_score, m_ticks, m_since_rst;
  bit [13:0] m_lfsr;
  int       m_map, m_type;
  bit       m_jl, m_jr, m_lastl, m_lastr, m_bufv, m_bufl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit [13:0] lfsr_next(input bit [13:0] v);
    int taps[4] = '{14, 13, 12, 2};
    bit fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return 14'(({18'd0, v} << 1) | fb);
  endfunction

  task automatic model_step(input bit r, input bit l, input bit rt, input bit tk, input bit f);
    bit pl, pr, one, was_strobe, go, go_left;
    if (r) begin
      m_state = 0; m_score = 0; m_ticks = 0; m_lfsr = SEED;
      m_map = 0; m_type = 0; m_jl = 0; m_jr = 0;
      m_lastl = 0; m_lastr = 0; m_since_rst = 0; m_bufv = 0; m_bufl = 0;
      return;
    end
    pl = l && !m_lastl && (m_since_rst > 0);
    pr = rt && !m_lastr && (m_since_rst > 0);
    one = (pl != pr);
    was_strobe = m_jl || m_jr;
    m_jl = 0; m_jr = 0; go = 0; go_left = 0;
    case (m_state)
      0: if (pl || pr) begin m_state = 1; m_score = 0; end
      1: begin
        if (BUF && was_strobe) begin m_state = 2; m_ticks = 0; end
        else if (one) begin go = 1; go_left = pl; m_state = 2; m_ticks = 0; end
      end
      2: begin
        if (BUF && one && !m_bufv) begin m_bufv = 1; m_bufl = pl; end
        if (tk) begin
          m_ticks++;
          if (m_ticks == JMS) begin
            m_ticks = 0;
            if (f) m_state = 3;
            else begin
              m_state = 1;
              m_score = (m_score + 1 > 999) ? 999 : m_score + 1;
              if (m_bufv) begin go = 1; go_left = m_bufl; end
            end
            m_bufv = 0;
          end
        end
      end
      default: if (pl || pr) m_state = 0;
    endcase
    if (go) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_map  = (m_lfsr % 128) | 8;
      m_type = (m_lfsr / 128) & m_map & 'h77;
      m_jl = go_left; m_jr = !go_left;
    end
    m_lastl = l; m_lastr = rt; m_since_rst++;
  endtask

  task automatic cyc(input bit r, input bit l, input bit rt, input bit tk, input bit f);
    rst = r; btn_left = l; btn_right = rt; one_ms_tick = tk; jump_fail = f;
    @(posedge clk);
    model_step(r, l, rt, tk, f);
    #1;
    chk("game_state", 32'(game_state), 32'(m_state));
    chk("blocks_en",  32'(blocks_en),  32'(m_state != 0));
    chk("jump_left",  32'(jump_left),  32'(m_jl));
    chk("jump_right", 32'(jump_right), 32'(m_jr));
    chk("layer_map",  32'(layer_map),  32'(m_map));
    chk("block_type", 32'(block_type), 32'(m_type));
    chk("score",      32'(score),      32'(m_score));
  endtask

  initial begin
    // reset state
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("lit_rst_state", 32'(game_state), 0);
    chk("lit_rst_en",    32'(blocks_en),  0);
    chk("lit_rst_map",   32'(layer_map),  0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // first press starts play without a strobe
    cyc(0, 0, 1, 0, 0);
    chk("lit_play_state", 32'(game_state), 1);
    chk("lit_play_score", 32'(score), 0);
    chk("lit_play_nostrobe", 32'(jump_right), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("lit_jr_strobe", 32'(jump_right), 1);
    chk("lit_busy", 32'(game_state), 2);
    chk("lit_map", 32'(layer_map), 32'h3A);
    chk("lit_type", 32'(block_type), 32'h20);
    chk("lit_model_map", 32'(m_map), 32'h3A);
    chk("lit_model_type", 32'(m_type), 32'h20);
    cyc(0, 0, 0, 0, 0);
    chk("lit_jr_one_cycle", 32'(jump_right), 0);

    // successful jump after 3 ticks
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lit_busy_2ticks", 32'(game_state), 2);
    cyc(0, 0, 0, 1, 0);
    chk("lit_ok_state", 32'(game_state), 1);
    chk("lit_ok_score", 32'(score), 1);

    // failing jump; early jump_fail must not end lockout
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("lit_fail_early", 32'(game_state), 2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lit_over_state", 32'(game_state), 3);
    chk("lit_over_en", 32'(blocks_en), 1);
    chk("lit_over_score", 32'(score), 1);
    cyc(0, 1, 0, 0, 0);
    chk("lit_idle_state", 32'(game_state), 0);
    chk("lit_idle_score", 32'(score), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("lit_restart_score", 32'(score), 0);

    // both buttons together are ignored
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("lit_both_state", 32'(game_state), 1);
    chk("lit_both_jl", 32'(jump_left), 0);
    chk("lit_both_jr", 32'(jump_right), 0);
    cyc(0, 0, 0, 0, 0);

    // press during lockout
    cyc(0, 1, 0, 0, 0);
    chk("lit_jl_strobe", 32'(jump_left), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lit_buf_state", 32'(game_state), 1);
    chk("lit_buf_strobe", 32'(jump_left), 32'(BUF));
    cyc(0, 0, 0, 0, 0);
    chk("lit_buf_after", 32'(game_state), BUF ? 2 : 1);

    // reset mid-lockout with btn_left held
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    chk("lit_mrst_state", 32'(game_state), 0);
    chk("lit_mrst_en", 32'(blocks_en), 0);
    chk("lit_mrst_jl", 32'(jump_left), 0);
    chk("lit_mrst_map", 32'(layer_map), 0);
    chk("lit_mrst_type", 32'(block_type), 0);
    chk("lit_mrst_score", 32'(score), 0);
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("lit_held_idle", 32'(game_state), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("lit_repress_play", 32'(game_state), 1);

    // saturate the score
    for (int i = 0; i < 1002; i++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      repeat (JMS) cyc(0, 0, 0, 1, 0);
    end
    chk("lit_sat_score", 32'(score), 999);
    chk("lit_sat_state", 32'(game_state), 1);

    // random play
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
